// File: rtl/index_slice_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_tpu
//  Description : Shared types and constants for the lane index slice generator
//  Revision    : 1.0  initial release
// ============================================================================
package pkg_tpu;

    localparam int IDXGEN_NUM_CH     = 3;
    localparam int IDXGEN_WIDTH_IDX  = 8;
    localparam int IDXGEN_WIDTH_LEN  = 8;
    localparam int IDXGEN_WIDTH_MASK = 16;

    typedef enum logic [1:0] {
        LINEAR = 2'd0,
        WINDOW = 2'd1,
        MASKED = 2'd2,
        SIMT   = 2'd3
    } idxgen_mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } idxgen_state_t;

    // Request configuration at the default geometry; base[0] is the low slice
    typedef struct packed {
        idxgen_mode_t                                             mode;
        logic [IDXGEN_NUM_CH-1:0][IDXGEN_WIDTH_IDX-1:0]           base;
        logic [IDXGEN_NUM_CH-1:0][IDXGEN_WIDTH_IDX-1:0]           stride;
        logic [IDXGEN_WIDTH_LEN-1:0]                              window;
        logic [IDXGEN_WIDTH_LEN-1:0]                              length;
        logic [IDXGEN_WIDTH_MASK-1:0]                             mask;
    } idxgen_cfg_t;

endpackage
`default_nettype wire

// File: rtl/index_slice_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : index_slice_gen_if
//  Description : Request / index-stream bundle of the lane index slice generator
//  Revision    : 1.0  initial release
// ============================================================================
interface index_slice_gen_if #(
    parameter int NUM_CH     = 3,
    parameter int WIDTH_IDX  = 8,
    parameter int WIDTH_LEN  = 8,
    parameter int WIDTH_MASK = 16
) ();
    logic                          I_Stall;
    logic                          I_Req;
    logic [1:0]                    I_Mode;
    logic [NUM_CH*WIDTH_IDX-1:0]   I_Base;
    logic [NUM_CH*WIDTH_IDX-1:0]   I_Stride;
    logic [WIDTH_LEN-1:0]          I_Window;
    logic [WIDTH_LEN-1:0]          I_Length;
    logic [WIDTH_IDX-1:0]          I_ThreadID;
    logic [WIDTH_MASK-1:0]         I_Mask;
    logic                          O_Busy;
    logic                          O_Valid;
    logic [NUM_CH*WIDTH_IDX-1:0]   O_Index;
    logic [WIDTH_LEN-1:0]          O_Count;
    logic                          O_Done;

    modport master (
        output I_Stall, I_Req, I_Mode, I_Base, I_Stride, I_Window,
               I_Length, I_ThreadID, I_Mask,
        input  O_Busy, O_Valid, O_Index, O_Count, O_Done
    );

    modport slave (
        input  I_Stall, I_Req, I_Mode, I_Base, I_Stride, I_Window,
               I_Length, I_ThreadID, I_Mask,
        output O_Busy, O_Valid, O_Index, O_Count, O_Done
    );
endinterface
`default_nettype wire

// File: rtl/index_slice_gen_mask_scan.sv
`default_nettype none
// ============================================================================
//  Module      : index_mask_scan
//  Description : Finds the lowest set mask bit at or above a start position
//  Revision    : 1.0  initial release
// ============================================================================
module index_mask_scan #(
    parameter int WIDTH_MASK = 16,
    parameter int WIDTH_POS  = 8
) (
    input  wire  [WIDTH_MASK-1:0] i_mask,
    input  wire  [WIDTH_POS-1:0]  i_start,
    output logic [WIDTH_POS-1:0]  o_pos,
    output logic                  o_found
);

    // Priority encoder: scanning downward lets the lowest qualifying bit win
    always_comb begin
        o_pos   = '0;
        o_found = 1'b0;
        for (int j = WIDTH_MASK - 1; j >= 0; j--) begin
            if (i_mask[j] && (j >= int'(i_start))) begin
                o_found = 1'b1;
                o_pos   = WIDTH_POS'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/index_slice_gen.sv
`default_nettype none
// ============================================================================
//  Module      : index_slice_gen
//  Description : Multi-channel operand index sequencer (linear, 2-D window,
//                mask-skipping and SIMT-offset access), one index set / cycle
//  Revision    : 1.0  initial release
// ============================================================================
module index_slice_gen
    import pkg_tpu::*;
#(
    parameter int LANE_ID    = 0,
    parameter int NUM_CH     = IDXGEN_NUM_CH,
    parameter int WIDTH_IDX  = 8,
    parameter int WIDTH_LEN  = 8,
    parameter int WIDTH_MASK = 16
) (
    input wire               clock,
    input wire               reset,
    index_slice_gen_if.slave bus
);

    idxgen_state_t          r_state;
    idxgen_mode_t           r_mode;
    logic [WIDTH_IDX-1:0]   r_base   [NUM_CH];
    logic [WIDTH_IDX-1:0]   r_stride [NUM_CH];
    logic [WIDTH_IDX-1:0]   r_acc    [NUM_CH];
    logic [WIDTH_IDX-1:0]   r_idx    [NUM_CH];
    logic [WIDTH_LEN-1:0]   r_win, r_len, r_w, r_count;
    logic [WIDTH_MASK-1:0]  r_mask;
    logic                   r_valid, r_done;

    idxgen_mode_t           w_in_mode;
    logic                   w_idle, w_found, w_more, w_empty, w_wrap;
    logic                   w_first_last, w_next_last;
    logic [WIDTH_MASK-1:0]  w_lim, w_above, w_scan_mask;
    logic [WIDTH_LEN-1:0]   w_scan_start, w_pos, w_in_win;
    logic [WIDTH_LEN-1:0]   w_first_k, w_next_k, w_next_w;
    logic [WIDTH_IDX-1:0]   w_offset;
    logic [WIDTH_IDX-1:0]   w_bsel [NUM_CH];
    logic [WIDTH_IDX-1:0]   w_ssel [NUM_CH];
    logic [WIDTH_IDX-1:0]   w_mask_idx  [NUM_CH];
    logic [WIDTH_IDX-1:0]   w_first_idx [NUM_CH];
    logic [WIDTH_IDX-1:0]   w_next_acc  [NUM_CH];
    logic [WIDTH_IDX-1:0]   w_next_idx  [NUM_CH];

    assign w_idle    = (r_state == S_IDLE);
    assign w_in_mode = idxgen_mode_t'(bus.I_Mode);

    // Mask bits at or beyond the request length never produce elements
    always_comb begin
        for (int j = 0; j < WIDTH_MASK; j++) begin
            w_lim[j] = (j < int'(bus.I_Length));
        end
    end

    // Bits strictly above the current scan result, for last-element lookahead
    always_comb begin
        for (int j = 0; j < WIDTH_MASK; j++) begin
            w_above[j] = (j > int'(w_pos));
        end
    end

    // While idle the scanner looks at the incoming request; in RUN it walks the latched mask
    assign w_scan_mask  = w_idle ? (bus.I_Mask & w_lim) : r_mask;
    assign w_scan_start = w_idle ? '0 : r_count + 1'b1;
    assign w_more       = |(w_scan_mask & w_above);

    index_mask_scan #(
        .WIDTH_MASK (WIDTH_MASK),
        .WIDTH_POS  (WIDTH_LEN)
    ) u_scan (
        .i_mask  (w_scan_mask),
        .i_start (w_scan_start),
        .o_pos   (w_pos),
        .o_found (w_found)
    );

    // SIMT offset is formed once, at accept, and folded into the start accumulator
    assign w_offset = bus.I_ThreadID * WIDTH_IDX'(bus.I_Length) + WIDTH_IDX'(LANE_ID);
    assign w_in_win = (bus.I_Window == '0) ? bus.I_Length : bus.I_Window;

    assign w_empty      = (bus.I_Length == '0) || ((w_in_mode == MASKED) && !w_found);
    assign w_first_k    = (w_in_mode == MASKED) ? w_pos : '0;
    assign w_first_last = (w_in_mode == MASKED) ? !w_more : (bus.I_Length == WIDTH_LEN'(1));

    assign w_wrap      = (r_w == r_win - 1'b1);
    assign w_next_w    = w_wrap ? '0 : r_w + 1'b1;
    assign w_next_k    = (r_mode == MASKED) ? w_pos : r_count + 1'b1;
    assign w_next_last = (r_mode == MASKED) ? !w_more : (r_count + WIDTH_LEN'(2) == r_len);

    // Masked elements jump arbitrarily far, so their index is formed directly from k
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_bsel[c]     = w_idle ? bus.I_Base[c*WIDTH_IDX +: WIDTH_IDX]   : r_base[c];
            w_ssel[c]     = w_idle ? bus.I_Stride[c*WIDTH_IDX +: WIDTH_IDX] : r_stride[c];
            w_mask_idx[c] = w_bsel[c] + WIDTH_IDX'(w_pos) * w_ssel[c];
        end
    end

    // First element at accept and the successor of the current element in RUN
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            case (w_in_mode)
                SIMT:    w_first_idx[c] = bus.I_Base[c*WIDTH_IDX +: WIDTH_IDX] + w_offset;
                MASKED:  w_first_idx[c] = w_mask_idx[c];
                default: w_first_idx[c] = bus.I_Base[c*WIDTH_IDX +: WIDTH_IDX];
            endcase
            w_next_acc[c] = r_acc[c] + r_stride[c];
            w_next_idx[c] = w_next_acc[c];
            case (r_mode)
                MASKED: begin
                    w_next_acc[c] = r_acc[c];
                    w_next_idx[c] = w_mask_idx[c];
                end
                WINDOW: begin
                    w_next_acc[c] = w_wrap ? r_acc[c] + r_stride[c] : r_acc[c];
                    w_next_idx[c] = w_next_acc[c] + WIDTH_IDX'(w_next_w);
                end
                default: ;
            endcase
        end
    end

    // Control FSM with registered outputs; stall freezes everything including accept
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_mode  <= LINEAR;
            r_win   <= '0;
            r_len   <= '0;
            r_w     <= '0;
            r_count <= '0;
            r_mask  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_base[c]   <= '0;
                r_stride[c] <= '0;
                r_acc[c]    <= '0;
                r_idx[c]    <= '0;
            end
        end else if (!bus.I_Stall) begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    if (bus.I_Req) begin
                        r_mode <= w_in_mode;
                        r_win  <= w_in_win;
                        r_len  <= bus.I_Length;
                        r_mask <= w_scan_mask;
                        r_w    <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            r_base[c]   <= bus.I_Base[c*WIDTH_IDX +: WIDTH_IDX];
                            r_stride[c] <= bus.I_Stride[c*WIDTH_IDX +: WIDTH_IDX];
                            r_acc[c]    <= w_first_idx[c];
                        end
                        if (w_empty) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_valid <= 1'b1;
                            r_done  <= w_first_last;
                            r_count <= w_first_k;
                            for (int c = 0; c < NUM_CH; c++) begin
                                r_idx[c] <= w_first_idx[c];
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (r_done) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_count <= w_next_k;
                        r_done  <= w_next_last;
                        r_w     <= w_next_w;
                        for (int c = 0; c < NUM_CH; c++) begin
                            r_acc[c] <= w_next_acc[c];
                            r_idx[c] <= w_next_idx[c];
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.O_Busy  = (r_state != S_IDLE);
    assign bus.O_Valid = r_valid;
    assign bus.O_Count = r_count;
    assign bus.O_Done  = r_done;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_out
            assign bus.O_Index[c*WIDTH_IDX +: WIDTH_IDX] = r_idx[c];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_index_slice_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_index_slice_gen
//  Description : Self-checking bench for index_slice_gen with a reference model
//  Revision    : 1.0  initial release
// ============================================================================
module tb_index_slice_gen;
    import pkg_tpu::*;

    localparam int NCH  = 3;
    localparam int WI   = 8;
    localparam int WL   = 8;
    localparam int WM   = 16;
    localparam int LANE = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clock = ~clock;

    index_slice_gen_if #(.NUM_CH(NCH), .WIDTH_IDX(WI), .WIDTH_LEN(WL), .WIDTH_MASK(WM)) u_bus ();

    index_slice_gen #(
        .LANE_ID (LANE), .NUM_CH (NCH), .WIDTH_IDX (WI), .WIDTH_LEN (WL), .WIDTH_MASK (WM)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_bus)
    );

    typedef struct {
        logic [WL-1:0]     k;
        logic [NCH*WI-1:0] idx;
    } elem_t;

    elem_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected element list from the closed-form rules (multiply, div/mod)
    function automatic void model(input idxgen_cfg_t cfg, input logic [WI-1:0] tid);
        int    n, weff, lim, v;
        elem_t e;
        exp_q.delete();
        n    = int'(cfg.length);
        weff = (cfg.window == 0) ? n : int'(cfg.window);
        lim  = (n < WM) ? n : WM;
        for (int k = 0; k < n; k++) begin
            if (cfg.mode == MASKED && (k >= lim || !cfg.mask[k])) continue;
            for (int c = 0; c < NCH; c++) begin
                case (cfg.mode)
                    WINDOW:  v = int'(cfg.base[c]) + (k / weff) * int'(cfg.stride[c]) + (k % weff);
                    SIMT:    v = int'(cfg.base[c]) + int'(tid) * n + LANE + k * int'(cfg.stride[c]);
                    default: v = int'(cfg.base[c]) + k * int'(cfg.stride[c]);
                endcase
                e.idx[c*WI +: WI] = WI'(v);
            end
            e.k = WL'(k);
            exp_q.push_back(e);
        end
    endfunction

    function automatic idxgen_cfg_t mk(input idxgen_mode_t m, input int b0, b1, b2,
                                       input int s0, s1, s2, input int win, len, mask);
        idxgen_cfg_t c;
        c.mode   = m;
        c.base[0] = WI'(b0); c.base[1] = WI'(b1); c.base[2] = WI'(b2);
        c.stride[0] = WI'(s0); c.stride[1] = WI'(s1); c.stride[2] = WI'(s2);
        c.window = WL'(win);
        c.length = WL'(len);
        c.mask   = WM'(mask);
        return c;
    endfunction

    task automatic drive_cfg(input idxgen_cfg_t cfg, input logic [WI-1:0] tid);
        u_bus.I_Mode     = cfg.mode;
        u_bus.I_Base     = cfg.base;
        u_bus.I_Stride   = cfg.stride;
        u_bus.I_Window   = cfg.window;
        u_bus.I_Length   = cfg.length;
        u_bus.I_Mask     = cfg.mask;
        u_bus.I_ThreadID = tid;
    endtask

    task automatic scramble();
        u_bus.I_Mode     = 2'($urandom);
        u_bus.I_Base     = 24'($urandom);
        u_bus.I_Stride   = 24'($urandom);
        u_bus.I_Window   = 8'($urandom);
        u_bus.I_Length   = 8'($urandom);
        u_bus.I_Mask     = 16'($urandom);
        u_bus.I_ThreadID = 8'($urandom);
    endtask

    // One request from accept to idle; called at a negedge with the DUT idle
    task automatic run_req(input string name, input idxgen_cfg_t cfg, input logic [WI-1:0] tid,
                           input int stall_at, input int stall_len, input bit rnd);
        int ptr, n, stalled;
        bit st;
        model(cfg, tid);
        n = exp_q.size();
        drive_cfg(cfg, tid);
        u_bus.I_Req   = 1'b1;
        u_bus.I_Stall = 1'b0;
        @(negedge clock);
        scramble();
        if (n == 0) begin
            chk({name, ".fin_done"},  64'(u_bus.O_Done),  64'd1);
            chk({name, ".fin_valid"}, 64'(u_bus.O_Valid), 64'd0);
            chk({name, ".fin_busy"},  64'(u_bus.O_Busy),  64'd1);
            u_bus.I_Req = 1'($urandom);
            @(negedge clock);
            chk({name, ".post_done"}, 64'(u_bus.O_Done), 64'd0);
        end else begin
            ptr     = 0;
            stalled = 0;
            while (ptr < n) begin
                chk($sformatf("%s.valid%0d", name, ptr), 64'(u_bus.O_Valid), 64'd1);
                chk($sformatf("%s.idx%0d",   name, ptr), 64'(u_bus.O_Index), 64'(exp_q[ptr].idx));
                chk($sformatf("%s.cnt%0d",   name, ptr), 64'(u_bus.O_Count), 64'(exp_q[ptr].k));
                chk($sformatf("%s.done%0d",  name, ptr), 64'(u_bus.O_Done),  64'(ptr == n - 1));
                chk($sformatf("%s.busy%0d",  name, ptr), 64'(u_bus.O_Busy),  64'd1);
                st = 1'b0;
                if (ptr == stall_at && stalled < stall_len) begin
                    st = 1'b1;
                    stalled++;
                end else if (rnd && $urandom_range(0, 3) == 0) begin
                    st = 1'b1;
                end
                u_bus.I_Stall = st;
                u_bus.I_Req   = 1'($urandom);
                @(negedge clock);
                if (!st) ptr++;
            end
            chk({name, ".end_valid"}, 64'(u_bus.O_Valid), 64'd0);
            chk({name, ".end_done"},  64'(u_bus.O_Done),  64'd0);
        end
        chk({name, ".end_busy"}, 64'(u_bus.O_Busy), 64'd0);
        u_bus.I_Req   = 1'b0;
        u_bus.I_Stall = 1'b0;
    endtask

    initial begin
        idxgen_cfg_t cfg;
        u_bus.I_Req   = 1'b0;
        u_bus.I_Stall = 1'b0;
        drive_cfg(mk(LINEAR, 0, 0, 0, 0, 0, 0, 0, 0, 0), '0);
        repeat (2) @(negedge clock);
        chk("rst.valid", 64'(u_bus.O_Valid), 64'd0);
        chk("rst.busy",  64'(u_bus.O_Busy),  64'd0);
        chk("rst.done",  64'(u_bus.O_Done),  64'd0);
        chk("rst.index", 64'(u_bus.O_Index), 64'd0);
        chk("rst.count", 64'(u_bus.O_Count), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Stall has priority over accept
        drive_cfg(mk(LINEAR, 4, 10, 0, 1, 2, 3, 0, 4, 0), '0);
        u_bus.I_Req   = 1'b1;
        u_bus.I_Stall = 1'b1;
        @(negedge clock);
        chk("stall_idle.busy", 64'(u_bus.O_Busy), 64'd0);
        chk("stall_idle.valid", 64'(u_bus.O_Valid), 64'd0);
        u_bus.I_Stall = 1'b0;

        run_req("linear",  mk(LINEAR, 4, 10, 0, 1, 2, 3, 0, 4, 0), '0, -1, 0, 0);
        run_req("window",  mk(WINDOW, 0, 0, 0, 8, 8, 8, 3, 6, 0), '0, -1, 0, 0);
        run_req("win0",    mk(WINDOW, 5, 1, 9, 8, 8, 8, 0, 5, 0), '0, -1, 0, 0);
        run_req("masked",  mk(MASKED, 0, 0, 0, 1, 1, 1, 0, 8, 16'h00A5), '0, -1, 0, 0);
        run_req("mask0",   mk(MASKED, 0, 0, 0, 1, 1, 1, 0, 8, 16'h0000), '0, -1, 0, 0);
        run_req("stall",   mk(LINEAR, 0, 0, 0, 1, 1, 1, 0, 4, 0), '0, 1, 2, 0);
        run_req("wrap",    mk(LINEAR, 254, 254, 254, 1, 1, 1, 0, 4, 0), '0, -1, 0, 0);
        run_req("simt",    mk(SIMT, 0, 0, 0, 1, 1, 1, 0, 4, 0), 8'd3, -1, 0, 0);
        run_req("len0",    mk(LINEAR, 7, 7, 7, 1, 1, 1, 0, 0, 0), '0, -1, 0, 0);

        // Abort mid-run by asynchronous reset
        drive_cfg(mk(LINEAR, 3, 3, 3, 1, 1, 1, 0, 10, 0), '0);
        u_bus.I_Req = 1'b1;
        @(negedge clock);
        u_bus.I_Req = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("abort.valid", 64'(u_bus.O_Valid), 64'd0);
        chk("abort.busy",  64'(u_bus.O_Busy),  64'd0);
        chk("abort.done",  64'(u_bus.O_Done),  64'd0);
        chk("abort.index", 64'(u_bus.O_Index), 64'd0);
        chk("abort.count", 64'(u_bus.O_Count), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_req("after_abort", mk(LINEAR, 4, 10, 0, 1, 2, 3, 0, 4, 0), '0, -1, 0, 0);

        // Randomized requests with random stalls and input churn
        for (int t = 0; t < 40; t++) begin
            cfg = mk(idxgen_mode_t'($urandom_range(0, 3)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 20)), int'($urandom_range(0, 65535)));
            run_req($sformatf("rnd%0d", t), cfg, 8'($urandom), -1, 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
